// File: rtl/tdd_sched.sv
// TDD/FDD frame scheduler: per-sample frame counter with TX/RX window decode.
// Define TDD_SCHED_ADJ_EN to enable the one-shot signed frame length correction.
module tdd_sched #(
  parameter int CW = 24,
  parameter int FW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          tddmode,
  input  logic [CW-1:0] frame_len,
  input  logic [CW-1:0] tstart,
  input  logic [CW-1:0] tend,
  input  logic [CW-1:0] rstart,
  input  logic [CW-1:0] rend,
  input  logic [CW-1:0] frame_adj,
  input  logic          adj_req,
  output logic [CW-1:0] cnt,
  output logic          sync,
  output logic          oen,
  output logic          ien,
  output logic [FW-1:0] frame_cnt,
  output logic          adj_pending
);

  typedef enum logic {IDLE, RUN} state_t;

`ifdef TDD_SCHED_ADJ_EN
  localparam bit ADJ_EN = 1'b1;
`else
  localparam bit ADJ_EN = 1'b0;
`endif

  localparam logic signed [CW+1:0] T_MIN = (CW+2)'(2);
  localparam logic signed [CW+1:0] T_MAX = $signed({2'b00, {CW{1'b1}}});

  function automatic logic in_window(input logic [CW-1:0] c, input logic [CW-1:0] s,
                                     input logic [CW-1:0] e);
    if (s < e)      return (c >= s) && (c < e);
    else if (s > e) return (c >= s) || (c < e);
    else            return 1'b0;
  endfunction

  // Frame length after signed correction, saturated to [2, 2^CW-1].
  function automatic logic [CW-1:0] frame_len_sat(input logic [CW-1:0] len,
                                                  input logic signed [CW-1:0] adj);
    logic signed [CW+1:0] sum;
    sum = $signed({2'b00, len}) + $signed({{2{adj[CW-1]}}, adj});
    if (sum < T_MIN)      return T_MIN[CW-1:0];
    else if (sum > T_MAX) return T_MAX[CW-1:0];
    else                  return sum[CW-1:0];
  endfunction

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sync_q, sync_d, oen_q, oen_d, ien_q, ien_d;
  logic [FW-1:0]         fc_q, fc_d;
  logic                  pend_q, pend_d, act_q, act_d;
  logic signed [CW-1:0]  adj_q, adj_d;
  logic [CW-1:0]         tc_q, tc_d;
  logic [CW-1:0]         flen_sh_q, ts_sh_q, te_sh_q, rs_sh_q, re_sh_q;
  logic [CW-1:0]         flen_sel, ts_sel, te_sel, rs_sel, re_sel, t_new;
  logic                  load, sh_load, use_adj;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    sync_d  = 1'b0;
    fc_d    = fc_q;
    pend_d  = pend_q;
    act_d   = act_q;
    adj_d   = adj_q;
    load    = 1'b0;
    use_adj = 1'b0;
    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        act_d  = 1'b0;
        if (enable) begin
          state_d = RUN;
          load    = 1'b1;
          sync_d  = 1'b1;
          fc_d    = fc_q + FW'(1);
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          pend_d  = 1'b0;
          act_d   = 1'b0;
        end else if (cnt_q == tc_q) begin
          load   = 1'b1;
          sync_d = 1'b1;
          fc_d   = fc_q + FW'(1);
          // act_q marks the adjusted frame; its end retires the pending request.
          if (act_q) begin
            act_d  = 1'b0;
            pend_d = 1'b0;
          end else if (pend_q) begin
            act_d   = 1'b1;
            use_adj = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (ADJ_EN && enable && adj_req && !pend_q) begin
          adj_d  = $signed(frame_adj);
          pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A starting frame decodes from the values being loaded into the shadows.
    sh_load  = (state_q == IDLE) || load;
    flen_sel = sh_load ? frame_len : flen_sh_q;
    ts_sel   = sh_load ? tstart    : ts_sh_q;
    te_sel   = sh_load ? tend      : te_sh_q;
    rs_sel   = sh_load ? rstart    : rs_sh_q;
    re_sel   = sh_load ? rend      : re_sh_q;
    t_new    = frame_len_sat(flen_sel, use_adj ? adj_q : '0);
    tc_d     = load ? (t_new - CW'(1)) : tc_q;

    oen_d = 1'b0;
    ien_d = 1'b0;
    if (state_d == RUN) begin
      oen_d = tddmode ? in_window(cnt_d, ts_sel, te_sel) : 1'b1;
      ien_d = tddmode ? in_window(cnt_d, rs_sel, re_sel) : 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sync_q  <= 1'b0;
      oen_q   <= 1'b0;
      ien_q   <= 1'b0;
      fc_q    <= '0;
      pend_q  <= 1'b0;
      act_q   <= 1'b0;
      adj_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      oen_q   <= oen_d;
      ien_q   <= ien_d;
      fc_q    <= fc_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      adj_q   <= adj_d;
    end
  end

  always_ff @(posedge clk) begin
    tc_q <= tc_d;
    if (sh_load) begin
      flen_sh_q <= frame_len;
      ts_sh_q   <= tstart;
      te_sh_q   <= tend;
      rs_sh_q   <= rstart;
      re_sh_q   <= rend;
    end
  end

  assign cnt         = cnt_q;
  assign sync        = sync_q;
  assign oen         = oen_q;
  assign ien         = ien_q;
  assign frame_cnt   = fc_q;
  assign adj_pending = pend_q;

endmodule
